plru_set_assoc: RTL and testbench

PLRU_SET_ASSOC -- requirements
Module: plru_set_assoc

---
 rtl/plru_set_assoc.sv | 119 +++++++++++
 tb/tb_plru_set_assoc.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/plru_set_assoc.sv
// Tree-PLRU replacement for a set-associative cache with invalid-first victim selection.
// Victim is registered one cycle after the request. A flush clears one set per cycle and ignores all inputs while busy.
module plru_set_assoc #(
    parameter int WAYS = 8,
    parameter int SETS = 16
) (
    input  logic                     clk_i,
    input  logic                     rstn_i,
    input  logic                     access_hit_i,
    input  logic [$clog2(SETS)-1:0]  access_set_i,
    input  logic [$clog2(WAYS)-1:0]  access_way_i,
    input  logic                     repl_req_i,
    input  logic [$clog2(SETS)-1:0]  repl_set_i,
    input  logic [WAYS-1:0]          valid_ways_i,
    input  logic                     flush_i,
    output logic                     repl_valid_o,
    output logic [$clog2(WAYS)-1:0]  repl_way_o,
    output logic                     busy_o
);
    localparam int LW = $clog2(WAYS);
    localparam int SW = $clog2(SETS);
    localparam int N  = WAYS - 1;

    typedef enum logic {IDLE, FLUSH} state_t;

    state_t          state, state_nxt;
    logic [SW-1:0]   cnt, cnt_nxt;
    logic [N-1:0]    tree [SETS];
    logic [N-1:0]    hit_tree;
    logic [LW-1:0]   victim;
    logic            hit_ok;
    logic            req_ok;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (flush_i) begin
                    state_nxt = FLUSH;
                    cnt_nxt   = '0;
                end
            end
            FLUSH: begin
                cnt_nxt = cnt + 1'b1;
                if (cnt == SW'(SETS - 1)) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // A flush request in the same cycle wins over a hit; out-of-range sets never update.
    assign hit_ok = (state == IDLE) && access_hit_i && !flush_i && (int'(access_set_i) < SETS);
    assign req_ok = (state == IDLE) && repl_req_i;
    assign busy_o = (state == FLUSH);

    // Each node on the hit path points away from the half that was just used.
    always_comb begin
        int node;
        hit_tree = '0;
        node     = 0;
        if (int'(access_set_i) < SETS) hit_tree = tree[access_set_i];
        for (int l = 0; l < LW; l++) begin
            hit_tree[node] = ~access_way_i[LW-1-l];
            node = 2 * node + 1 + int'(access_way_i[LW-1-l]);
        end
    end

    always_comb begin
        int node;
        victim = '0;
        node   = 0;
        if (int'(repl_set_i) < SETS) begin
            for (int l = 0; l < LW; l++) begin
                victim[LW-1-l] = tree[repl_set_i][node];
                node = 2 * node + 1 + int'(tree[repl_set_i][node]);
            end
            if (!(&valid_ways_i)) begin
                victim = '0;
                for (int i = WAYS - 1; i >= 0; i--) begin
                    if (!valid_ways_i[i]) victim = LW'(i);
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int s = 0; s < SETS; s++) tree[s] <= '0;
        end else if (state == FLUSH) begin
            tree[cnt] <= '0;
        end else if (hit_ok) begin
            tree[access_set_i] <= hit_tree;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            repl_valid_o <= 1'b0;
            repl_way_o   <= '0;
        end else begin
            repl_valid_o <= req_ok;
            if (req_ok) repl_way_o <= victim;
        end
    end
endmodule

// File: tb/tb_plru_set_assoc.sv
// Directed and random checks of plru_set_assoc (8 ways, 4 sets) against a per-level/prefix PLRU model.
module tb_plru_set_assoc;
    localparam int WAYS = 8;
    localparam int SETS = 4;
    localparam int LW   = 3;
    localparam int SW   = 2;

    logic          clk_i = 1'b0;
    logic          rstn_i = 1'b1;
    logic          access_hit_i = 1'b0;
    logic [SW-1:0] access_set_i = '0;
    logic [LW-1:0] access_way_i = '0;
    logic          repl_req_i = 1'b0;
    logic [SW-1:0] repl_set_i = '0;
    logic [7:0]    valid_ways_i = 8'hFF;
    logic          flush_i = 1'b0;
    logic          repl_valid_o;
    logic [LW-1:0] repl_way_o;
    logic          busy_o;

    plru_set_assoc #(.WAYS(WAYS), .SETS(SETS)) dut (
        .clk_i        (clk_i),
        .rstn_i       (rstn_i),
        .access_hit_i (access_hit_i),
        .access_set_i (access_set_i),
        .access_way_i (access_way_i),
        .repl_req_i   (repl_req_i),
        .repl_set_i   (repl_set_i),
        .valid_ways_i (valid_ways_i),
        .flush_i      (flush_i),
        .repl_valid_o (repl_valid_o),
        .repl_way_o   (repl_way_o),
        .busy_o       (busy_o)
    );

    always #5 clk_i = ~clk_i;

    int n_assert = 0;
    int n_fail   = 0;

    // Model: m_dir[set][level][prefix] = 1 means "next victim lies in the upper half" of that subtree.
    bit m_dir [SETS][LW][WAYS];
    int m_busy = 0;
    int m_last = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic m_clear(input int s);
        for (int l = 0; l < LW; l++)
            for (int p = 0; p < WAYS; p++) m_dir[s][l][p] = 1'b0;
    endtask

    task automatic m_hit(input int s, input int w);
        for (int l = 0; l < LW; l++)
            m_dir[s][l][w >> (LW - l)] = (((w >> (LW - 1 - l)) & 1) == 0);
    endtask

    function automatic int m_victim(input int s, input logic [7:0] vw);
        int v;
        for (int i = 0; i < WAYS; i++) if (!vw[i]) return i;
        v = 0;
        for (int l = 0; l < LW; l++) v = v * 2 + int'(m_dir[s][l][v]);
        return v;
    endfunction

    // Drive one cycle of stimulus, advance the model, then check all outputs after the edge.
    task automatic cycle(input string tag, input bit hit, input int hs, input int hw,
                         input bit req, input int rs, input logic [7:0] vw, input bit fl);
        bit exp_v;
        int exp_w;
        access_hit_i = hit;
        access_set_i = SW'(hs);
        access_way_i = LW'(hw);
        repl_req_i   = req;
        repl_set_i   = SW'(rs);
        valid_ways_i = vw;
        flush_i      = fl;
        exp_v = req && (m_busy == 0);
        exp_w = exp_v ? m_victim(rs, vw) : m_last;
        if (m_busy > 0) begin
            m_clear(SETS - m_busy);
            m_busy--;
        end else if (fl) begin
            m_busy = SETS;
        end else if (hit) begin
            m_hit(hs, hw);
        end
        @(posedge clk_i);
        #1;
        check({tag, "_valid"}, 32'(repl_valid_o), 32'(exp_v));
        check({tag, "_way"},   32'(repl_way_o),   32'(exp_w));
        check({tag, "_busy"},  32'(busy_o),       32'(m_busy > 0));
        m_last = exp_w;
        access_hit_i = 1'b0;
        repl_req_i   = 1'b0;
        flush_i      = 1'b0;
    endtask

    task automatic do_reset(input string tag);
        rstn_i = 1'b0;
        #1;
        check({tag, "_valid"}, 32'(repl_valid_o), 32'd0);
        check({tag, "_way"},   32'(repl_way_o),   32'd0);
        check({tag, "_busy"},  32'(busy_o),       32'd0);
        for (int s = 0; s < SETS; s++) m_clear(s);
        m_busy = 0;
        m_last = 0;
        @(posedge clk_i);
        #1;
        rstn_i = 1'b1;
    endtask

    initial begin
        #2;
        do_reset("reset");

        cycle("first_req", 0, 0, 0, 1, 2, 8'hFF, 0);
        check("first_req_const", 32'(repl_way_o), 32'd0);
        cycle("idle_hold", 0, 0, 0, 0, 0, 8'hFF, 0);

        cycle("hit_s2w0", 1, 2, 0, 0, 0, 8'hFF, 0);
        cycle("tree_s2", 0, 0, 0, 1, 2, 8'hFF, 0);
        check("tree_s2_const", 32'(repl_way_o), 32'd4);
        cycle("tree_s1", 0, 0, 0, 1, 1, 8'hFF, 0);
        check("tree_s1_const", 32'(repl_way_o), 32'd0);

        cycle("inv_first", 0, 0, 0, 1, 2, 8'b1111_0111, 0);
        check("inv_first_const", 32'(repl_way_o), 32'd3);

        // Flush with a simultaneous hit: hit dropped; inputs during busy ignored, second flush ignored.
        cycle("flush_go", 1, 1, 5, 0, 0, 8'hFF, 1);
        for (int i = 0; i < SETS; i++) begin
            check("busy_const", 32'(busy_o), 32'd1);
            cycle("busy_in", 1, 0, 7, 1, 2, 8'hFF, i == 1);
        end
        check("busy_done", 32'(busy_o), 32'd0);
        cycle("post_flush_s2", 0, 0, 0, 1, 2, 8'hFF, 0);
        check("post_flush_s2_const", 32'(repl_way_o), 32'd0);
        cycle("post_flush_s1", 0, 0, 0, 1, 1, 8'hFF, 0);
        cycle("post_flush_s0", 0, 0, 0, 1, 0, 8'hFF, 0);
        check("post_flush_s0_const", 32'(repl_way_o), 32'd0);

        cycle("same_cyc", 1, 2, 0, 1, 2, 8'hFF, 0);
        check("same_cyc_const", 32'(repl_way_o), 32'd0);
        cycle("same_next", 0, 0, 0, 1, 2, 8'hFF, 0);
        check("same_next_const", 32'(repl_way_o), 32'd4);

        // Flush together with a request is served from pre-flush state, then reset aborts the flush.
        cycle("hit_s3w0", 1, 3, 0, 0, 0, 8'hFF, 0);
        cycle("flush_req", 0, 0, 0, 1, 3, 8'hFF, 1);
        check("flush_req_const", 32'(repl_way_o), 32'd4);
        cycle("mid_flush", 0, 0, 0, 0, 0, 8'hFF, 0);
        do_reset("reset_mid");
        for (int s = 0; s < SETS; s++) begin
            cycle("after_rst", 0, 0, 0, 1, s, 8'hFF, 0);
            check("after_rst_const", 32'(repl_way_o), 32'd0);
        end
        check("after_rst_busy", 32'(busy_o), 32'd0);

        for (int n = 0; n < 400; n++) begin
            logic [7:0] vw;
            vw = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
            cycle("rand", $urandom_range(0, 1) == 1, int'($urandom_range(0, SETS - 1)),
                  int'($urandom_range(0, WAYS - 1)), $urandom_range(0, 1) == 1,
                  int'($urandom_range(0, SETS - 1)), vw, $urandom_range(0, 39) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
